// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge-event arbiter: per-channel edge
// selection encoding, the event record and a modulo index helper.
package edge_evt_pkg;

    // Widest channel index supported (N_CH up to 16).
    localparam int CH_W_MAX = 4;

    // Per-channel edge selection, packed as {fall_en, rise_en}.
    typedef struct packed {
        logic fall_en;
        logic rise_en;
    } edge_sel_t;

    localparam edge_sel_t EDGE_RISE = '{fall_en: 1'b0, rise_en: 1'b1};
    localparam edge_sel_t EDGE_FALL = '{fall_en: 1'b1, rise_en: 1'b0};
    localparam edge_sel_t EDGE_BOTH = '{fall_en: 1'b1, rise_en: 1'b1};

    // One presented event: originating channel and polarity.
    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic                rise;
    } evt_t;

    // (base + off) mod n, for base < n and off <= n, without a divider.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/edge_pend_cell.sv
// One channel of the edge-event arbiter: input synchroniser, edge detector,
// edge qualification and the single-entry pending slot with sticky overflow.
module edge_pend_cell
    import edge_evt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sig_in,
    input  logic      ch_en,
    input  edge_sel_t edge_sel,
    input  logic      grant,
    input  logic      ovf_clr,
    output logic      pend,
    output logic      pend_rise,
    output logic      ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   qual;
    logic                   ovf_set;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev;
    assign fall = ~s & prev;
    assign qual = ch_en & ((rise & edge_sel.rise_en) | (fall & edge_sel.fall_en));

    // A new edge is dropped only if the slot is occupied and not being emptied now.
    assign ovf_set = qual & pend & ~grant;

    // Synchroniser chain plus one-cycle delayed copy of the synchronised level.
    // NOTE: non-blocking assignments make every stage sample the old value of the
    // previous stage, so the chain shifts by exactly one flop per clock.
    // NOTE: these flops are reset to 0, so an input already high at reset release
    // is seen as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q[0] <= sig_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev <= s;
        end
    end

    // Pending slot: IDLE <-> PEND, refilled in the same cycle it is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_rise <= 1'b0;
        end else if (!ch_en) begin
            pend      <= 1'b0;
        end else if (qual && (!pend || grant)) begin
            pend      <= 1'b1;
            pend_rise <= rise;
        end else if (grant) begin
            pend      <= 1'b0;
        end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller. Each channel detects qualified edges
// and holds one pending event; a round-robin selector feeds a single
// valid/ready output register.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   sig_in,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [2*N_CH-1:0] edge_sel,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_rise,
    output logic [N_CH-1:0]   ovf,
    input  logic [N_CH-1:0]   ovf_clr
);

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] pend_rise;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] rr;
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] idx;
    logic            load;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_pend_cell #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .sig_in    (sig_in[i]),
            .ch_en     (ch_en[i]),
            .edge_sel  (edge_sel_t'(edge_sel[2*i +: 2])),
            .grant     (grant[i]),
            .ovf_clr   (ovf_clr[i]),
            .pend      (pend[i]),
            .pend_rise (pend_rise[i]),
            .ovf       (ovf[i])
        );
    end

    // Round-robin pick: first pending channel scanning rr+1, rr+2, ... rr.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    // NOTE: every variable gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        sel = rr;
        idx = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = CH_W'(wrap_idx(int'(rr), k, N_CH));
            if (pend[idx]) begin
                sel = idx;
            end
        end
    end

    // Output register is free when empty (EMPTY) or being drained (XFER).
    always_comb begin
        load  = (~evt_valid | evt_ready) & (|pend);
        grant = '0;
        if (load) begin
            grant = N_CH'(1) << sel;
        end
    end

    // Output register and rr pointer; contents frozen while HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
            rr        <= CH_W'(N_CH - 1);
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_ch    <= sel;
            evt_rise  <= pend_rise[sel];
            rr        <= sel;
        end else begin
            evt_valid <= evt_valid & ~evt_ready;
        end
    end

endmodule
